// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared 4-bit ALU.
// Two requesters, one op in flight, tagged response port.
module alu_arbiter #(
  parameter int W   = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [OPW-1:0] req0_ctrl,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [OPW-1:0] req1_ctrl,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_ctrl,
  input  logic [W-1:0]   alu_res,
  input  logic           alu_car,
  input  logic           alu_of,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_res,
  output logic           rsp_car,
  output logic           rsp_of,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   rr_last;
  logic   id;
  logic   grant0, grant1;
  logic   accept;

  // Round-robin grant: a lone requester wins, a tie goes away from rr_last.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | rr_last);
    grant1     = req1_valid & (~req0_valid | ~rr_last);
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    accept     = req0_ready | req1_ready;
    busy       = (state != IDLE);
  end

  // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP, RESP -> IDLE on drain.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand latch on grant, result capture after EXEC, response drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last   <= 1'b1;
      id        <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= '0;
      rsp_car   <= 1'b0;
      rsp_of    <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        alu_a    <= req1_ready ? req1_a : req0_a;
        alu_b    <= req1_ready ? req1_b : req0_b;
        alu_ctrl <= req1_ready ? req1_ctrl : req0_ctrl;
        id       <= req1_ready;
        rr_last  <= req1_ready;
      end
      if (state == EXEC) begin
        rsp_res   <= alu_res;
        rsp_car   <= alu_car;
        rsp_of    <= alu_of;
        rsp_id    <= id;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
